// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter
//
// Purpose: FSM state type, one-hot grant encodings and strobe width used by
//          sram_arbiter and sram_rr_pick.
// Ports:   none (package).
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_M0   = 2'b01;
  localparam logic [1:0] G_M1   = 2'b10;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int STRB_W         = DEF_DATA_WIDTH / 8;

endpackage

// File: rtl/sram_rr_pick.sv
// rtl/sram_rr_pick.sv - combinational two-way round-robin picker
//
// Purpose: choose one requester from req after removing masked requesters.
//          A lone request wins; on a tie the master that did not win last
//          time (!last_grant) wins.
// Ports:
//   req[1:0]    in   request vector, bit 0 = master 0, bit 1 = master 1
//   last_grant  in   0 = master 0 won last, 1 = master 1 won last
//   mask[1:0]   in   requesters excluded from this pick
//   pick[1:0]   out  one-hot winner, 00 when nobody is eligible
module sram_rr_pick
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic [1:0] mask,
  output logic [1:0] pick
);

  logic [1:0] w_req;

  assign w_req = req & ~mask;

  always_comb begin
    pick = G_NONE;
    case (w_req)
      2'b01:   pick = G_M0;
      2'b10:   pick = G_M1;
      2'b11:   pick = last_grant ? G_M0 : G_M1;
      default: pick = G_NONE;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-master round-robin arbiter for a single-port SRAM
//
// Purpose: serialise valid/ready accesses from master 0 (CPU) and master 1
//          (config/DMA agent) onto one 1-cycle-read SRAM. IDLE -> ACCESS
//          (SRAM driven) -> RESP (ready pulse, read data returned).
//          Optional macro SRAM_ARB_PROT_EN blocks master-0 writes into
//          [PROT_BASE, PROT_BASE+PROT_LEN) and flags them on m0_err.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   m0_valid/m0_ready             master 0 handshake (ready is a 1-cycle pulse)
//   m0_addr/m0_wdata/m0_wstrb     master 0 request, wstrb==0 means read
//   m0_rdata, m0_err              master 0 read data / protection error
//   m1_*                          master 1, same as master 0 without err
//   mem_wen/mem_addr/mem_wdata    SRAM request, active only in ACCESS
//   mem_rdata                     SRAM read data, one cycle after mem_addr
//   grant                         one-hot owner of current transaction
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32
`ifdef SRAM_ARB_PROT_EN
  ,
  parameter int PROT_BASE  = 768,
  parameter int PROT_LEN   = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [STRB_W-1:0]     m0_wstrb,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [STRB_W-1:0]     m1_wstrb,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [STRB_W-1:0]     mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            grant
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_grant;
  logic [1:0]            w_grant_nxt;
  logic                  r_last_grant;
  logic                  w_last_grant_nxt;
  logic [DATA_WIDTH-1:0] r_m0_rdata;
  logic [DATA_WIDTH-1:0] r_m1_rdata;
  logic [1:0]            w_pick;
  logic [1:0]            w_mask;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [STRB_W-1:0]     w_sel_wstrb;
  logic                  w_block;

  // In RESP the winner's valid is still high for the transaction just
  // finished, so it is masked out; only the other master may be picked.
  assign w_mask = (r_state == RESP) ? r_grant : G_NONE;

  sram_rr_pick u_pick (
    .req        ({m1_valid, m0_valid}),
    .last_grant (r_last_grant),
    .mask       (w_mask),
    .pick       (w_pick)
  );

  assign w_sel_addr  = r_grant[1] ? m1_addr  : m0_addr;
  assign w_sel_wdata = r_grant[1] ? m1_wdata : m0_wdata;
  assign w_sel_wstrb = r_grant[1] ? m1_wstrb : m0_wstrb;

`ifdef SRAM_ARB_PROT_EN
  localparam logic [ADDR_WIDTH-1:0] L_PROT_LO = ADDR_WIDTH'(PROT_BASE);
  localparam logic [ADDR_WIDTH-1:0] L_PROT_HI = ADDR_WIDTH'(PROT_BASE + PROT_LEN);

  logic r_err;

  assign w_block = r_grant[0] && (m0_wstrb != '0) &&
                   (m0_addr >= L_PROT_LO) && (m0_addr < L_PROT_HI);

  // Remember the verdict from ACCESS so err lines up with the RESP ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (r_state == ACCESS) begin
      r_err <= w_block;
    end
  end

  assign m0_err = m0_ready & r_err;
`else
  assign w_block = 1'b0;
  assign m0_err  = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      IDLE: begin
        if (w_pick != G_NONE) begin
          w_state_nxt = ACCESS;
          w_grant_nxt = w_pick;
        end
      end
      ACCESS: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        w_last_grant_nxt = r_grant[1];
        if (w_pick != G_NONE) begin
          w_state_nxt = ACCESS;
          w_grant_nxt = w_pick;
        end else begin
          w_state_nxt = IDLE;
          w_grant_nxt = G_NONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = G_NONE;
      end
    endcase
  end

  // The SRAM sees a request only during ACCESS; a reset landing in ACCESS
  // does not suppress the write because the SRAM itself is not reset.
  always_comb begin
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == ACCESS) begin
      mem_addr  = w_sel_addr;
      mem_wdata = w_sel_wdata;
      mem_wen   = w_block ? '0 : w_sel_wstrb;
    end
  end

  // A reset arriving in RESP aborts the transaction, so no ready escapes.
  assign m0_ready = (r_state == RESP) && r_grant[0] && !reset;
  assign m1_ready = (r_state == RESP) && r_grant[1] && !reset;

  // Read data is live from the SRAM during the ready cycle and held after.
  assign m0_rdata = m0_ready ? mem_rdata : r_m0_rdata;
  assign m1_rdata = m1_ready ? mem_rdata : r_m1_rdata;
  assign grant    = r_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= G_NONE;
      r_last_grant <= 1'b1;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      if (m0_ready) begin
        r_m0_rdata <= mem_rdata;
      end
      if (m1_ready) begin
        r_m1_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter (optional SRAM_ARB_PROT_EN)
module tb_sram_arbiter;

  localparam int AW  = 22;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int PLO = 768;
  localparam int PHI = 768 + 16;
`ifdef SRAM_ARB_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    v     = '0;
  logic [AW-1:0] a [2];
  logic [DW-1:0] d [2];
  logic [SW-1:0] s [2];

  logic          m0_ready, m1_ready, m0_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [SW-1:0] mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    grant;

  logic [DW-1:0] sram [1024];
  logic [DW-1:0] em   [1024];

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [1:0] rdy_seen = '0;
  bit   rnd_en = 1'b0;
  bit   stop   = 1'b0;

  sram_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0_valid  (v[0]),
    .m0_ready  (m0_ready),
    .m0_addr   (a[0]),
    .m0_wdata  (d[0]),
    .m0_wstrb  (s[0]),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_valid  (v[1]),
    .m1_ready  (m1_ready),
    .m1_addr   (a[1]),
    .m1_wdata  (d[1]),
    .m1_wstrb  (s[1]),
    .m1_rdata  (m1_rdata),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= sram[mem_addr[9:0]];
    for (int b = 0; b < SW; b++)
      if (mem_wen[b]) sram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: a decision is made whenever the arbiter is free
  // (or in a response cycle, excluding that response's owner); each decision
  // schedules an SRAM access one cycle later and a response one after that.
  int            cyc = 0, nd = 0, last = 1;
  int            acc_cyc = -1, acc_w = 0, resp_cyc = -1, resp_w = 0, excl_cyc = -1, excl_w = 0;
  logic [AW-1:0] acc_a;
  logic [DW-1:0] acc_d, resp_rd;
  logic [SW-1:0] acc_s;
  bit            resp_err, resp_read;

  always @(negedge clk) begin : model
    logic [1:0]    eg, er, req;
    logic [SW-1:0] ewen;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    logic          eerr, blk;
    int            w;
    eg = '0; er = '0; ewen = '0; eaddr = '0; ewd = '0; eerr = 1'b0;
    if (acc_cyc == cyc) begin
      eg[acc_w] = 1'b1;
      eaddr = acc_a;
      ewd   = acc_d;
      blk   = PROT && acc_w == 0 && acc_s != '0 && acc_a >= AW'(PLO) && acc_a < AW'(PHI);
      ewen  = blk ? '0 : acc_s;
      resp_rd = em[acc_a[9:0]];
      if (!blk)
        for (int b = 0; b < SW; b++)
          if (acc_s[b]) em[acc_a[9:0]][8*b +: 8] = acc_d[8*b +: 8];
      resp_err  = blk;
      resp_read = (acc_s == '0);
      resp_w    = acc_w;
      resp_cyc  = cyc + 1;
    end else if (resp_cyc == cyc) begin
      eg[resp_w] = 1'b1;
      if (!reset) er[resp_w] = 1'b1;
      eerr = !reset && resp_err && resp_w == 0;
    end
    chk("grant", grant, eg);
    chk("ready", {m1_ready, m0_ready}, er);
    chk("mem_wen", mem_wen, ewen);
    chk("mem_addr", mem_addr, eaddr);
    chk("mem_wdata", mem_wdata, ewd);
    chk("m0_err", m0_err, eerr);
    if (er[0] && resp_read) chk("m0_rdata", m0_rdata, resp_rd);
    if (er[1] && resp_read) chk("m1_rdata", m1_rdata, resp_rd);
    rdy_seen = rdy_seen | {m1_ready, m0_ready};
    if (reset) begin
      acc_cyc = -1; resp_cyc = -1; excl_cyc = -1; nd = cyc + 1; last = 1;
    end else if (cyc >= nd) begin
      req = v;
      if (excl_cyc == cyc) req[excl_w] = 1'b0;
      if (req != 2'b00) begin
        if (req == 2'b11) w = (last == 1) ? 0 : 1;
        else              w = (req == 2'b01) ? 0 : 1;
        acc_cyc = cyc + 1; acc_w = w; acc_a = a[w]; acc_d = d[w]; acc_s = s[w];
        nd = cyc + 2; excl_cyc = cyc + 2; excl_w = w; last = w;
      end else begin
        nd = cyc + 1;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic new_req(int i);
    v[i] = 1'b1;
    a[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(760, 790)) : AW'($urandom_range(0, 1023));
    d[i] = $urandom;
    s[i] = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom_range(1, 15));
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_en)
        for (int i = 0; i < 2; i++) begin
          if (rdy_seen[i]) begin
            rdy_seen[i] = 1'b0;
            if (!stop && $urandom_range(0, 2) != 0) new_req(i);
            else v[i] = 1'b0;
          end else if (v[i] && !grant[i] && (stop || $urandom_range(0, 15) == 0)) begin
            v[i] = 1'b0;
          end else if (!v[i] && !stop && $urandom_range(0, 3) == 0) begin
            new_req(i);
          end
        end
    end
  end

  initial begin : directed
    logic [17:0] pat;
    int          nrdy;
    for (int i = 0; i < 2; i++) begin a[i] = '0; d[i] = '0; s[i] = '0; end
    for (int i = 0; i < 1024; i++) begin sram[i] = $urandom; em[i] = sram[i]; end
    sram[5]   = 32'hDEADBEEF; em[5]   = 32'hDEADBEEF;
    sram[10]  = 32'hAABBCCDD; em[10]  = 32'hAABBCCDD;
    sram[2]   = 32'h0BADF00D; em[2]   = 32'h0BADF00D;
    sram[770] = 32'h00000000; em[770] = 32'h00000000;

    repeat (3) @(posedge clk);
    nclk();
    chk("rst_grant", grant, 2'b00);
    chk("rst_ready", {m1_ready, m0_ready}, 2'b00);
    chk("rst_wen", mem_wen, 4'h0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 64'h0);
    tick(); reset = 1'b0;

    // m0 read of addr 5
    tick(); v[0] = 1'b1; a[0] = 22'd5; s[0] = 4'h0;
    nclk();
    nclk(); chk("rd5_grant", grant, 2'b01); chk("rd5_addr", mem_addr, 5);
    nclk(); chk("rd5_ready", m0_ready, 1'b1); chk("rd5_data", m0_rdata, 32'hDEADBEEF);
    tick(); v[0] = 1'b0;
    nclk(); chk("rd5_idle", grant, 2'b00);

    // m0 partial write then readback of addr 10
    tick(); v[0] = 1'b1; a[0] = 22'd10; d[0] = 32'h12345678; s[0] = 4'b0011;
    nclk();
    nclk(); chk("wr10_wen", mem_wen, 4'b0011);
    nclk(); chk("wr10_wen_off", mem_wen, 4'b0000); chk("wr10_ready", m0_ready, 1'b1);
    tick(); s[0] = 4'h0;
    nclk(); nclk();
    nclk(); chk("rb10_ready", m0_ready, 1'b1); chk("rb10_data", m0_rdata, 32'hAABB5678);
    tick(); v[0] = 1'b0;

    // m1 holds valid through its RESP only: no re-grant straight from RESP
    tick(); v[1] = 1'b1; a[1] = 22'd2; s[1] = 4'h0;
    nclk(); nclk();
    nclk(); chk("m1_ready", m1_ready, 1'b1); chk("m1_data", m1_rdata, 32'h0BADF00D);
    tick(); v[1] = 1'b0;
    nclk(); chk("stale_grant0", grant, 2'b00);
    nclk(); chk("stale_grant1", grant, 2'b00);

    // Fresh reset, then both masters request continuously
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    tick(); v = 2'b11; a[0] = 22'd1; s[0] = 4'h0; a[1] = 22'd2; s[1] = 4'h0;
    pat = '0;
    for (int k = 0; k < 9; k++) begin
      nclk();
      pat[2*k +: 2] = {m1_ready, m0_ready};
    end
    chk("alt_order", pat, 18'b10_00_01_00_10_00_01_00_00);
    tick(); v = 2'b00;
    repeat (4) nclk();

    // Reset while m1 is in ACCESS
    tick(); v[1] = 1'b1; a[1] = 22'd3; s[1] = 4'h0;
    nclk();
    tick(); reset = 1'b1; v[1] = 1'b0;
    nclk(); chk("rstacc_grant", grant, 2'b10); chk("rstacc_addr", mem_addr, 3);
    tick(); reset = 1'b0;
    nclk();
    chk("post_rst_out", {grant, m1_ready, m0_ready, m0_err, mem_wen}, 0);
    chk("post_rst_mem", {mem_addr, mem_wdata}, 0);
    chk("post_rst_rdata", {m1_rdata, m0_rdata}, 64'h0);
    nrdy = 0;
    repeat (4) begin nclk(); nrdy += int'(m1_ready); end
    chk("no_m1_ready", nrdy, 0);

`ifdef SRAM_ARB_PROT_EN
    tick(); v[0] = 1'b1; a[0] = 22'd770; d[0] = 32'h55AA55AA; s[0] = 4'hF;
    nclk();
    nclk(); chk("prot_wen", mem_wen, 4'h0);
    nclk(); chk("prot_ready_err", {m0_ready, m0_err}, 2'b11);
    tick(); v[0] = 1'b0;
    chk("prot_sram", sram[770], 32'h0);
    tick(); v[1] = 1'b1; a[1] = 22'd770; d[1] = 32'h55AA55AA; s[1] = 4'hF;
    nclk();
    nclk(); chk("m1_prot_wen", mem_wen, 4'hF);
    nclk(); chk("m1_prot_ready", {m1_ready, m0_err}, 2'b10);
    tick(); v[1] = 1'b0;
    tick(); v[0] = 1'b1; a[0] = 22'd770; s[0] = 4'h0;
    nclk(); nclk();
    nclk(); chk("prot_read", {m0_ready, m0_err, m0_rdata}, {2'b10, 32'h55AA55AA});
    tick(); v[0] = 1'b0;
`endif

    repeat (3) nclk();
    rdy_seen = '0;
    rnd_en   = 1'b1;
    repeat (3000) @(posedge clk);
    stop = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter that shares the single-port on-chip SRAM (mem_mem, 1-cycle synchronous read) between master 0 (CPU path, downstream of mem_mpu) and master 1 (security/config agent, e.g. an MPU-table loader or DMA).
- Both masters use the native valid/ready memory handshake. The arbiter serialises accesses, selects round-robin, and returns read data with a one-cycle ready pulse.
- Sits between mem_mpu and sram in picosoc.

Parameters:
- ADDR_WIDTH, 22, word address width on all ports.
- DATA_WIDTH, 32, data width; strobe width = DATA_WIDTH/8.
- PROT_BASE, 768, first word of the protected region (used only with SRAM_ARB_PROT_EN).
- PROT_LEN, 16, protected region length in words (used only with SRAM_ARB_PROT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_valid  in  1  master 0 request.
- m0_ready  out  1  master 0 transaction complete (1-cycle pulse).
- m0_addr  in  ADDR_WIDTH  master 0 word address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_wstrb  in  4  master 0 byte strobes; 0 = read.
- m0_rdata  out  DATA_WIDTH  master 0 read data, valid with m0_ready.
- m0_err  out  1  protection violation, pulses with m0_ready (SRAM_ARB_PROT_EN only, else tied 0).
- m1_valid / m1_ready / m1_addr / m1_wdata / m1_wstrb / m1_rdata  as for m0, for master 1.
- mem_wen  out  4  SRAM byte write enables.
- mem_addr  out  ADDR_WIDTH  SRAM word address.
- mem_wdata  out  DATA_WIDTH  SRAM write data.
- mem_rdata  in  DATA_WIDTH  SRAM read data, one cycle after mem_addr.
- grant  out  2  one-hot owner of the current transaction; 00 when idle.

Behaviour:
- One clock (clk). Reset is synchronous and active-high on reset.
- Reset values:
  - all readys, m0_err, mem_wen, grant = 0.
  - mem_addr, mem_wdata, m0_rdata, m1_rdata = 0.
  - state = IDLE; last_grant = 1, so master 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any valid is high, pick a winner, latch it into grant, go to ACCESS.
  - If only one valid is high, that master wins. If both are high, the winner is !last_grant.
  - Otherwise stay in IDLE.
- ACCESS:
  - mem_addr, mem_wdata and mem_wen (= winner's wstrb) are driven from the winner's inputs for exactly this cycle.
  - Go to RESP.
- RESP:
  - Winner's ready = 1 for one cycle; winner's rdata = mem_rdata, registered in the same cycle ready is high. For writes, rdata is don't-care.
  - mem_wen = 0. last_grant is updated to the winner.
  - Re-arbitration in RESP considers only the non-winner, because the winner's valid is still high this cycle. If the other master's valid is high, go to ACCESS with it granted; else go to IDLE.
- Latency:
  - From IDLE: valid seen at cycle 0, SRAM access at cycle 1, ready at cycle 2.
  - Back-to-back alternating masters: one transaction every 2 cycles.
- Fairness: with both masters continuously requesting, grants strictly alternate, so worst-case wait is one foreign transaction.
- mem_wen is nonzero only in ACCESS. No SRAM write ever occurs in IDLE or RESP.
- The master is required to hold addr/wdata/wstrb stable while valid is high. The arbiter samples them in ACCESS.
- A valid dropped before grant is ignored with no side effect. A valid dropped after grant still completes the access: ready still pulses and the write still lands.
- Reset mid-operation: the transaction is aborted. If reset is in ACCESS, the write still occurs that cycle (the SRAM is not reset). No ready is issued after reset; state returns to IDLE.
- Address passes through unmodified; no range check without the option.

Optional Feature:
- Macro: SRAM_ARB_PROT_EN.
- Defined:
  - A master-0 write (wstrb != 0) with PROT_BASE <= m0_addr < PROT_BASE+PROT_LEN has mem_wen forced to 0 in ACCESS.
  - m0_ready still pulses in RESP and m0_err pulses with it.
  - Master-0 reads of the region are allowed.
  - Master 1 is never restricted.
  - Compare width is ADDR_WIDTH, unsigned.
- Undefined: no comparator is generated and m0_err is tied to 0.

Decomposition:
- Package sram_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - localparams for the grant encodings G_NONE=2'b00, G_M0=2'b01, G_M1=2'b10.
  - STRB_W = DATA_WIDTH/8.
- One sub-module, sram_rr_pick: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant, mask[1:0].
  - Output: one-hot pick.
  - mask implements the RESP-state exclusion of the current winner.

Test Plan:
- Reset, then m0 reads addr 5 (SRAM[5]=32'hDEADBEEF) -> grant=01 at cycle 1, m0_ready at cycle 2 with m0_rdata=32'hDEADBEEF, grant=00 afterwards.
- m0 writes addr 10, wdata 32'h12345678, wstrb 4'b0011 -> mem_wen=4'b0011 for exactly one cycle; a subsequent read of addr 10 returns 32'hxxxx5678 with the upper bytes unchanged.
- m0 and m1 both valid continuously, reading addrs 1 and 2 -> ready order m0, m1, m0, m1, with one ready every 2 cycles and no master granted twice in a row.
- m1 holds valid through its RESP cycle while m0 is idle -> returns to IDLE and does not re-grant m1 on its stale valid.
- Assert reset while in ACCESS for an m1 read -> no m1_ready is ever issued, and all outputs are 0 on the next cycle.
- SRAM_ARB_PROT_EN: m0 writes addr 770 -> mem_wen=0, m0_ready and m0_err pulse together, SRAM[770] unchanged; the same write from m1 -> SRAM[770] updated and m0_err stays 0.
